// File: rtl/tinycpu_ctrl_pkg.sv
// Shared definitions for the tinyCPU sequencer: opcodes, FSM states,
// instruction field positions and condition-code bit indices.
package tinycpu_ctrl_pkg;

  localparam int INSTR_W = 16;
  localparam int OPC_LSB = 12;
  localparam int OPC_W   = 4;
  localparam int RD_LSB  = 10;
  localparam int RS_LSB  = 8;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 8;

  localparam int CC_C = 1;
  localparam int CC_Z = 0;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_NOT  = 4'h5,
    OP_SHL  = 4'h6,
    OP_SHR  = 4'h7,
    OP_LDI  = 4'h8,
    OP_JMP  = 4'h9,
    OP_JZ   = 4'hA,
    OP_JC   = 4'hB,
    OP_HALT = 4'hC,
    OP_NOP  = 4'hD
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  // Opcodes 0-7 map one-to-one onto ALU operations.
  function automatic logic is_alu_op(input logic [OPC_W-1:0] opc);
    return (opc[OPC_W-1] == 1'b0);
  endfunction

endpackage

// File: rtl/tinycpu_ctrl_if.sv
// Sequencer-side bus: program ROM read port and ALU operand/result port.
interface tinycpu_ctrl_if #(
  parameter int PC_W   = 8,
  parameter int DATA_W = 8
);

  logic [PC_W-1:0]   rom_addr;
  logic [15:0]       rom_data;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_e;
  logic [1:0]        alu_cc;

  modport master (
    output rom_addr, alu_a, alu_b, alu_op,
    input  rom_data, alu_e, alu_cc
  );

  modport slave (
    input  rom_addr, alu_a, alu_b, alu_op,
    output rom_data, alu_e, alu_cc
  );

endinterface

// File: rtl/tinycpu_ctrl_regfile.sv
// General-purpose register file: two combinational read ports, one
// synchronous write port, asynchronous clear.
module tinycpu_ctrl_regfile #(
  parameter int NREG   = 4,
  parameter int DATA_W = 8,
  localparam int IDX_W = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  raddr_a_i,
  input  logic [IDX_W-1:0]  raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i
);

  logic [DATA_W-1:0] mem_q [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/tinycpu_ctrl.sv
// Multicycle fetch/decode/execute/writeback sequencer for the tinyCPU
// datapath; owns PC, IR, flags and the register file.
module tinycpu_ctrl
  import tinycpu_ctrl_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int DATA_W = 8,
  parameter int NREG   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  tinycpu_ctrl_if.master  bus,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic [2:0]      state
);

  localparam int IDX_W = $clog2(NREG);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [1:0]          flags_q, flags_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [3:0]          alu_op_q, alu_op_d;
  logic                halted_q, halted_d;

  logic [OPC_W-1:0]    opc;
  logic [IDX_W-1:0]    rd, rs;
  logic [IMM_W-1:0]    imm;
  logic [PC_W-1:0]     pc_inc;
  logic [DATA_W-1:0]   rd_val, rs_val;
  logic                rf_we;

  assign opc    = ir_q[OPC_LSB +: OPC_W];
  assign rd     = ir_q[RD_LSB +: IDX_W];
  assign rs     = ir_q[RS_LSB +: IDX_W];
  assign imm    = ir_q[IMM_LSB +: IMM_W];
  assign pc_inc = pc_q + PC_W'(1);

  // Operands are latched in DECODE and the write lands in WB, so a
  // same-register op (ADD R1,R1) always sees the pre-write value.
  tinycpu_ctrl_regfile #(.NREG(NREG), .DATA_W(DATA_W)) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .raddr_a_i (rd),
    .raddr_b_i (rs),
    .rdata_a_o (rd_val),
    .rdata_b_o (rs_val),
    .we_i      (rf_we),
    .waddr_i   (rd),
    .wdata_i   (result_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      flags_q  <= '0;
      result_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      flags_q  <= flags_d;
      result_q <= result_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    flags_d  = flags_q;
    result_d = result_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    halted_d = halted_q;
    rf_we    = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        if (run) begin
          ir_d    = bus.rom_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_alu_op(opc)) begin
          alu_a_d  = rd_val;
          alu_b_d  = rs_val;
          alu_op_d = opc;
        end
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (opc)
          OP_LDI: begin
            result_d = DATA_W'(imm);
            state_d  = S_WB;
          end
          OP_JMP:  pc_d = PC_W'(imm);
          OP_JZ:   pc_d = flags_q[CC_Z] ? PC_W'(imm) : pc_inc;
          OP_JC:   pc_d = flags_q[CC_C] ? PC_W'(imm) : pc_inc;
          OP_HALT: begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end
          default: begin
            if (is_alu_op(opc)) begin
              result_d = bus.alu_e;
              flags_d  = bus.alu_cc;
              state_d  = S_WB;
            end else begin
              pc_d = pc_inc;
            end
          end
        endcase
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign bus.rom_addr = pc_q;
  assign bus.alu_a    = alu_a_q;
  assign bus.alu_b    = alu_b_q;
  assign bus.alu_op   = alu_op_q;
  assign pc           = pc_q;
  assign halted       = halted_q;
  assign state        = state_q;

endmodule

// File: tb/tb_tinycpu_ctrl.sv
// Directed bench for tinycpu_ctrl: behavioural ROM and ALU around the
// sequencer, fixed-latency programs with hand-computed results.
module tb_tinycpu_ctrl;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [7:0] pc;
  logic       halted;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  tinycpu_ctrl_if bus ();

  tinycpu_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .bus    (bus),
    .pc     (pc),
    .halted (halted),
    .state  (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] rom_mem [256];
  assign bus.rom_data = rom_mem[bus.rom_addr];

  // Reference ALU: SUB reports borrow in the carry bit.
  logic [7:0] alu_res;
  logic       alu_c;
  always_comb begin
    alu_res = 8'h00;
    alu_c   = 1'b0;
    case (bus.alu_op)
      4'h0: {alu_c, alu_res} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      4'h1: {alu_c, alu_res} = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      4'h2: alu_res = bus.alu_a & bus.alu_b;
      4'h3: alu_res = bus.alu_a | bus.alu_b;
      4'h4: alu_res = bus.alu_a ^ bus.alu_b;
      4'h5: alu_res = ~bus.alu_a;
      4'h6: {alu_c, alu_res} = {bus.alu_a, 1'b0};
      4'h7: begin alu_res = bus.alu_a >> 1; alu_c = bus.alu_a[0]; end
      default: alu_res = 8'h00;
    endcase
  end
  assign bus.alu_e  = alu_res;
  assign bus.alu_cc = {alu_c, (alu_res == 8'h00)};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom_mem[i] = 16'hD000;
  endtask

  // Holds reset across two falling edges and releases on a falling edge,
  // so the next rising edge is cycle 1 of the program.
  task automatic start();
    rst_n = 1'b0;
    run   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    run   = 1'b1;
    clear_rom();

    // Load/add, then HALT at cycle 15
    rom_mem[0] = 16'h8401;
    rom_mem[1] = 16'h8802;
    rom_mem[2] = 16'h0600;
    rom_mem[3] = 16'hC000;
    @(negedge clk);
    @(negedge clk);
    chk("rst_state",  {29'd0, state}, 32'd0);
    chk("rst_pc",     {24'd0, pc}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_alu_a",  {24'd0, bus.alu_a}, 32'd0);
    chk("rst_alu_b",  {24'd0, bus.alu_b}, 32'd0);
    chk("rst_alu_op", {28'd0, bus.alu_op}, 32'd0);
    chk("rst_romaddr", {24'd0, bus.rom_addr}, 32'd0);
    rst_n = 1'b1;
    cycles(4);
    chk("ldi_pc", {24'd0, pc}, 32'd1);
    chk("ldi_r1", {24'd0, dut.u_regfile.mem_q[1]}, 32'h01);
    cycles(10);
    chk("add_halted_c14", {31'd0, halted}, 32'd0);
    cycles(1);
    chk("add_halted_c15", {31'd0, halted}, 32'd1);
    chk("add_state",      {29'd0, state}, 32'd4);
    chk("add_pc",         {24'd0, pc}, 32'd3);
    chk("add_r1",         {24'd0, dut.u_regfile.mem_q[1]}, 32'h03);
    chk("add_flags",      {30'd0, dut.flags_q}, 32'd0);
    chk("add_alu_a",      {24'd0, bus.alu_a}, 32'h01);
    chk("add_alu_b",      {24'd0, bus.alu_b}, 32'h02);
    cycles(3);
    chk("halt_sticky",    {29'd0, state}, 32'd4);

    // Zero flag, JZ taken
    clear_rom();
    rom_mem[0] = 16'h8005;
    rom_mem[1] = 16'h1000;
    rom_mem[2] = 16'hA010;
    start();
    cycles(11);
    chk("jz_taken_pc",    {24'd0, pc}, 32'h10);
    chk("jz_taken_flags", {30'd0, dut.flags_q}, 32'd1);
    chk("jz_taken_r0",    {24'd0, dut.u_regfile.mem_q[0]}, 32'd0);
    chk("jz_taken_state", {29'd0, state}, 32'd0);

    // Nonzero result, JZ falls through
    clear_rom();
    rom_mem[0] = 16'h8005;
    rom_mem[1] = 16'h1100;
    rom_mem[2] = 16'hA010;
    start();
    cycles(11);
    chk("jz_not_pc",    {24'd0, pc}, 32'd3);
    chk("jz_not_flags", {30'd0, dut.flags_q}, 32'd0);
    chk("jz_not_r0",    {24'd0, dut.u_regfile.mem_q[0]}, 32'h05);

    // Carry, JC taken
    clear_rom();
    rom_mem[0] = 16'h80FF;
    rom_mem[1] = 16'h8401;
    rom_mem[2] = 16'h0100;
    rom_mem[3] = 16'hB020;
    start();
    cycles(15);
    chk("jc_pc",    {24'd0, pc}, 32'h20);
    chk("jc_r0",    {24'd0, dut.u_regfile.mem_q[0]}, 32'h00);
    chk("jc_flags", {30'd0, dut.flags_q}, 32'd3);

    // PC wrap through NOP at 0xFF
    clear_rom();
    rom_mem[0] = 16'h90FF;
    start();
    cycles(3);
    chk("wrap_jmp_pc",  {24'd0, pc}, 32'hFF);
    chk("wrap_romaddr", {24'd0, bus.rom_addr}, 32'hFF);
    cycles(3);
    chk("wrap_nop_pc",  {24'd0, pc}, 32'h00);
    cycles(3);
    chk("wrap_loop_pc", {24'd0, pc}, 32'hFF);
    cycles(3);
    chk("wrap_loop2_pc", {24'd0, pc}, 32'h00);

    // Stall on run low; also same-register ADD R1,R1
    clear_rom();
    rom_mem[0] = 16'h8407;
    rom_mem[1] = 16'h0500;
    rom_mem[2] = 16'h8809;
    rom_mem[3] = 16'hC000;
    start();
    cycles(8);
    chk("stall_pre_pc", {24'd0, pc}, 32'd2);
    chk("same_reg_r1",  {24'd0, dut.u_regfile.mem_q[1]}, 32'h0E);
    run = 1'b0;
    cycles(5);
    chk("stall_state",  {29'd0, state}, 32'd0);
    chk("stall_pc",     {24'd0, pc}, 32'd2);
    chk("stall_alu_a",  {24'd0, bus.alu_a}, 32'h07);
    chk("stall_alu_b",  {24'd0, bus.alu_b}, 32'h07);
    chk("stall_alu_op", {28'd0, bus.alu_op}, 32'd0);
    chk("stall_r2",     {24'd0, dut.u_regfile.mem_q[2]}, 32'h00);
    run = 1'b1;
    cycles(1);
    chk("resume_state", {29'd0, state}, 32'd1);
    cycles(3);
    chk("resume_pc", {24'd0, pc}, 32'd3);
    chk("resume_r2", {24'd0, dut.u_regfile.mem_q[2]}, 32'h09);
    cycles(3);
    chk("resume_halted", {31'd0, halted}, 32'd1);

    // Async reset during EXEC of ADD
    clear_rom();
    rom_mem[0] = 16'h8401;
    rom_mem[1] = 16'h8802;
    rom_mem[2] = 16'h0600;
    rom_mem[3] = 16'hC000;
    start();
    cycles(10);
    chk("arst_pre_state", {29'd0, state}, 32'd2);
    chk("arst_pre_alu_a", {24'd0, bus.alu_a}, 32'h01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state",  {29'd0, state}, 32'd0);
    chk("arst_pc",     {24'd0, pc}, 32'd0);
    chk("arst_alu_a",  {24'd0, bus.alu_a}, 32'd0);
    chk("arst_alu_b",  {24'd0, bus.alu_b}, 32'd0);
    chk("arst_alu_op", {28'd0, bus.alu_op}, 32'd0);
    chk("arst_halted", {31'd0, halted}, 32'd0);
    chk("arst_r1",     {24'd0, dut.u_regfile.mem_q[1]}, 32'd0);
    chk("arst_flags",  {30'd0, dut.flags_q}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(1);
    chk("arst_restart_state", {29'd0, state}, 32'd1);
    chk("arst_restart_pc",    {24'd0, pc}, 32'd0);
    cycles(14);
    chk("arst_rerun_halted", {31'd0, halted}, 32'd1);
    chk("arst_rerun_r1",     {24'd0, dut.u_regfile.mem_q[1]}, 32'h03);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
